// File: rtl/sata_link_pkg.sv
// rtl/sata_link_pkg.sv - shared state, power-mode and primitive encodings for the SATA link controller
package sata_link_pkg;

  typedef enum logic [3:0] {
    ST_NOT_READY = 4'd0,
    ST_IDLE      = 4'd1,
    ST_PM_DENY   = 4'd2,
    ST_PM_ACK    = 4'd3,
    ST_PARTIAL   = 4'd4,
    ST_SLUMBER   = 4'd5,
    ST_WAKE      = 4'd6
  } link_state_t;

  typedef enum logic [1:0] {
    PM_ACTIVE  = 2'd0,
    PM_PARTIAL = 2'd1,
    PM_SLUMBER = 2'd2
  } pm_mode_t;

  // K28.3-led primitive dwords, byte 0 first on the wire
  localparam logic [31:0] PRIM_SYNC   = 32'hB5B5_957C;
  localparam logic [31:0] PRIM_PMACK  = 32'h9595_957C;
  localparam logic [31:0] PRIM_PMNACK = 32'hF5F5_957C;

endpackage

// File: rtl/sata_link_tx_mux.sv
// rtl/sata_link_tx_mux.sv - fixed-priority transmit mux, lowest busy channel wins over the fallback primitive
module sata_link_tx_mux #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]    ch_busy,
  input  logic [32*NUM_CH-1:0] ch_tx_dout,
  input  logic [NUM_CH-1:0]    ch_tx_is_k,
  input  logic [31:0]          prim_dout,
  input  logic                 prim_is_k,
  output logic [31:0]          tx_dout,
  output logic                 tx_is_k
);

  // Scan from the top so the lowest busy index is the last assignment
  always_comb begin
    tx_dout = prim_dout;
    tx_is_k = prim_is_k;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_busy[i]) begin
        tx_dout = ch_tx_dout[32*i +: 32];
        tx_is_k = ch_tx_is_k[i];
      end
    end
  end

endmodule

// File: rtl/sata_link_ctrl_pm.sv
// rtl/sata_link_ctrl_pm.sv - SATA link-layer control FSM with PMREQ handling; power management built under SATA_LINK_PM_EN
module sata_link_ctrl_pm
  import sata_link_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int PREQ_FILTER  = 2,
  parameter int PMACK_CYCLES = 4,
  parameter int WAKE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 phy_ready,
  input  logic                 platform_ready,
  input  logic                 detect_preq_s,
  input  logic                 detect_preq_p,
  input  logic                 pm_allow,
  input  logic                 host_wake,
  input  logic [NUM_CH-1:0]    ch_busy,
  input  logic [32*NUM_CH-1:0] ch_tx_dout,
  input  logic [NUM_CH-1:0]    ch_tx_is_k,
  output logic [NUM_CH-1:0]    ch_en,
  output logic [31:0]          tx_dout,
  output logic                 tx_is_k,
  output logic                 link_ready,
  output logic [1:0]           pm_state,
  output logic                 wake_req,
  output logic [3:0]           state
);

  localparam logic [3:0] PREQ_MAX = 4'(PREQ_FILTER);

  link_state_t cur_state, nxt_state;
  pm_mode_t    pm_mode;
  logic [3:0]  preq_cnt, preq_cnt_nxt;
  logic        preq_hit, preq_done, any_busy, link_hold;
  logic [31:0] prim_dout, mux_dout;
  logic        mux_is_k;

  assign preq_hit     = detect_preq_s | detect_preq_p;
  assign preq_cnt_nxt = !preq_hit ? 4'd0 :
                        (preq_cnt >= PREQ_MAX) ? PREQ_MAX : preq_cnt + 4'd1;
  assign preq_done    = (preq_cnt_nxt == PREQ_MAX);
  assign any_busy     = |ch_busy;
  assign link_hold    = (cur_state == ST_NOT_READY) || (cur_state == ST_IDLE) ||
                        (cur_state == ST_PM_DENY)   || (cur_state == ST_PM_ACK);

`ifdef SATA_LINK_PM_EN
  localparam logic [7:0]  ACK_LAST   = 8'(PMACK_CYCLES - 1);
  localparam logic [15:0] WAKE_LIMIT = 16'(WAKE_TIMEOUT);

  logic [7:0]  ack_cnt;
  logic [15:0] wake_cnt, wake_cnt_inc;
  logic        pm_slumber;

  assign wake_cnt_inc = wake_cnt + 16'd1;
`else
  logic unused_pm;
  assign unused_pm = pm_allow ^ host_wake ^ (PMACK_CYCLES == 0) ^ (WAKE_TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) cur_state <= ST_NOT_READY;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (!platform_ready) begin
      nxt_state = ST_NOT_READY;
    end else if (!phy_ready && link_hold) begin
      nxt_state = ST_NOT_READY;
    end else begin
      case (cur_state)
        ST_NOT_READY: nxt_state = ST_IDLE;
        ST_IDLE: begin
          if (preq_done && !any_busy) begin
`ifdef SATA_LINK_PM_EN
            nxt_state = pm_allow ? ST_PM_ACK : ST_PM_DENY;
`else
            nxt_state = ST_PM_DENY;
`endif
          end
        end
        ST_PM_DENY: if (!preq_hit) nxt_state = ST_IDLE;
`ifdef SATA_LINK_PM_EN
        ST_PM_ACK: if (ack_cnt == ACK_LAST) nxt_state = pm_slumber ? ST_SLUMBER : ST_PARTIAL;
        ST_PARTIAL, ST_SLUMBER: if (host_wake) nxt_state = ST_WAKE;
        ST_WAKE: begin
          // wake_cnt_inc counts WAKE cycles including the current one
          if (phy_ready && wake_cnt_inc >= 16'd2) nxt_state = ST_IDLE;
          else if (wake_cnt_inc == WAKE_LIMIT)   nxt_state = ST_NOT_READY;
        end
`endif
        default: nxt_state = ST_NOT_READY;
      endcase
    end
  end

  always_comb begin
    prim_dout = PRIM_SYNC;
    pm_mode   = PM_ACTIVE;
    wake_req  = 1'b0;
    case (cur_state)
      ST_PM_DENY: prim_dout = PRIM_PMNACK;
`ifdef SATA_LINK_PM_EN
      ST_PM_ACK:  prim_dout = PRIM_PMACK;
      ST_PARTIAL: pm_mode   = PM_PARTIAL;
      ST_SLUMBER: pm_mode   = PM_SLUMBER;
      ST_WAKE:    wake_req  = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !platform_ready) preq_cnt <= 4'd0;
    else                        preq_cnt <= preq_cnt_nxt;
  end

`ifdef SATA_LINK_PM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_cnt    <= 8'd0;
      wake_cnt   <= 16'd0;
      pm_slumber <= 1'b0;
    end else begin
      ack_cnt  <= (cur_state == ST_PM_ACK && nxt_state == ST_PM_ACK) ? ack_cnt + 8'd1 : 8'd0;
      wake_cnt <= (cur_state == ST_WAKE && nxt_state == ST_WAKE) ? wake_cnt_inc : 16'd0;
      if (cur_state == ST_IDLE && nxt_state == ST_PM_ACK) pm_slumber <= detect_preq_s;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) ch_en <= '0;
    else     ch_en <= (cur_state == ST_IDLE) ? '1 : '0;
  end

  sata_link_tx_mux #(.NUM_CH(NUM_CH)) u_tx_mux (
    .ch_busy    (ch_busy),
    .ch_tx_dout (ch_tx_dout),
    .ch_tx_is_k (ch_tx_is_k),
    .prim_dout  (prim_dout),
    .prim_is_k  (1'b1),
    .tx_dout    (mux_dout),
    .tx_is_k    (mux_is_k)
  );

  assign tx_dout    = rst ? PRIM_SYNC : mux_dout;
  assign tx_is_k    = rst ? 1'b1 : mux_is_k;
  assign link_ready = (cur_state == ST_IDLE) && !any_busy;
  assign pm_state   = pm_mode;
  assign state      = cur_state;

endmodule

// File: doc/sata_link_ctrl_pm.md
SATA_LINK_CTRL_PM -- requirements
Module: sata_link_ctrl_pm

Interface
REQ-001 Parameter NUM_CH, default 2: number of transmit sources (1..8); channel 0 has highest priority.
REQ-002 Parameter PREQ_FILTER, default 2: consecutive PMREQ cycles required before the block acts (1..15).
REQ-003 Parameter PMACK_CYCLES, default 4: number of cycles PMACK is transmitted before entering low power (1..255).
REQ-004 Parameter WAKE_TIMEOUT, default 1024: cycles WAKE waits for phy_ready before abandoning (2..65535).
REQ-005 Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- phy_ready  in  1  PHY link up.
- platform_ready  in  1  platform enable.
- detect_preq_s  in  1  PMREQ_S received.
- detect_preq_p  in  1  PMREQ_P received.
- pm_allow  in  1  policy: 1 = accept PM requests, 0 = deny them.
- host_wake  in  1  local wake request (pulse or level).
- ch_busy  in  NUM_CH  source owns the link.
- ch_tx_dout  in  32*NUM_CH  per-source dword; channel i occupies bits [32i+31:32i].
- ch_tx_is_k  in  NUM_CH  per-source K flag.
- ch_en  out  NUM_CH  registered enable to sources.
- tx_dout  out  32  dword to cont/PHY.
- tx_is_k  out  1  K flag.
- link_ready  out  1  block is IDLE and no source is busy.
- pm_state  out  2  0 = active, 1 = partial, 2 = slumber.
- wake_req  out  1  COMWAKE request to the PHY.
- state  out  4  debug state code.

Function
REQ-006 States are NOT_READY=0, IDLE=1, PM_DENY=2, PM_ACK=3, PARTIAL=4, SLUMBER=5, WAKE=6; any other code goes to NOT_READY on the next cycle.
REQ-007 Transition priority is: rst, then !platform_ready (to NOT_READY), then !phy_ready in NOT_READY/IDLE/PM_DENY/PM_ACK (to NOT_READY), then the per-state rules below.
REQ-008 NOT_READY: transmit SYNC; go to IDLE when phy_ready and platform_ready are both high.
REQ-009 ch_en is all ones, registered, only while the state is IDLE; otherwise it is zero.
REQ-010 Transmit mux: when any ch_busy bit is set, tx_dout/tx_is_k come from the lowest-index busy channel, combinationally, in every state; otherwise the block's own primitive is sent.
REQ-011 preq_cnt (4 bits) increments on each cycle where preq_s or preq_p is seen, saturates at PREQ_FILTER, and clears on any cycle with neither.
REQ-012 IDLE: when preq_cnt reaches PREQ_FILTER and ch_busy is zero, go to PM_ACK if pm_allow is high, else to PM_DENY. A PMREQ while a channel is busy is ignored.
REQ-013 Entering PM_ACK latches the PM type: slumber if preq_s is seen on the triggering cycle, partial otherwise (slumber wins when both are seen).
REQ-014 PM_DENY: transmit PMNAK; return to IDLE on the first cycle with no PMREQ.
REQ-015 PM_ACK: transmit PMACK for exactly PMACK_CYCLES cycles, then go to SLUMBER or PARTIAL according to the latched type.
REQ-016 PARTIAL/SLUMBER: transmit SYNC; pm_state = 1 or 2 respectively; phy_ready is ignored; go to WAKE when host_wake is high.
REQ-017 WAKE: wake_req is high; a 16-bit counter runs. Go to IDLE when phy_ready is high and the counter is at least 2. Go to NOT_READY when the counter reaches WAKE_TIMEOUT. The counter clears on entering WAKE.
REQ-018 pm_state is 0 in every state except PARTIAL and SLUMBER; wake_req is 0 outside WAKE.
REQ-019 link_ready = (state == IDLE) && ch_busy == 0.
REQ-020 When platform_ready drops mid-PM_ACK or mid-WAKE, the next state is NOT_READY and all counters clear.

Reset
REQ-021 On rst: state = NOT_READY; preq_cnt, the ack counter and the wake counter = 0; latched PM type = partial; ch_en = 0; pm_state = 0; wake_req = 0.
REQ-022 While rst is high, tx_dout = PRIM_SYNC and tx_is_k = 1 regardless of ch_busy.

Configuration
REQ-023 Macro SATA_LINK_PM_EN defined: full behaviour as above.
REQ-024 Macro SATA_LINK_PM_EN undefined:
- PM_ACK, PARTIAL, SLUMBER and WAKE are not built.
- A filtered PMREQ always goes to PM_DENY; pm_allow and host_wake are ignored.
- pm_state and wake_req are tied to 0.

Structure
REQ-025 Shared package sata_link_pkg holds the state encodings, the pm_state encodings, and the PRIM_SYNC/PRIM_PMACK/PRIM_PMNACK constants taken from the existing SATA defines.
REQ-026 Sub-module sata_link_tx_mux, parametrised by NUM_CH, implements the priority mux of REQ-010 together with the fallback primitive input.

Verification
REQ-027 Bring-up: rst 4 cycles, then phy_ready=1, platform_ready=1 -> state 0 then 1 one cycle later; ch_en = 2'b11 the following cycle; tx_dout = PRIM_SYNC.
REQ-028 Arbitration: ch_busy = 2'b11, ch0 = 0x11111111, ch1 = 0x22222222 -> tx_dout = 0x11111111. Drop bit 0 -> tx_dout = 0x22222222 in the same cycle.
REQ-029 Deny: pm_allow=0, preq_p high for 3 cycles -> PM_DENY entered after the 2nd cycle; PMNAK sent while preq stays high; IDLE on the first quiet cycle. A 1-cycle preq causes no transition.
REQ-030 Accept: pm_allow=1, preq_s and preq_p both high for 2 cycles -> PMACK for exactly 4 cycles, then SLUMBER with pm_state = 2. host_wake -> WAKE with wake_req=1; phy_ready held high -> IDLE after 2 cycles.
REQ-031 Wake timeout: in WAKE with phy_ready=0 for 1024 cycles -> NOT_READY, wake_req=0. platform_ready=0 during PM_ACK -> NOT_READY next cycle.
REQ-032 Build without SATA_LINK_PM_EN, pm_allow=1, preq_s for 2 cycles -> PM_DENY; pm_state = 0 throughout.
